// File: rtl/iq_frame_builder_if.sv
// Framed IQ output stream between the frame builder and the range detector.
//   adc_iq_tdata/dac_iq_tdata : framed ADC and delayed DAC samples {I,Q}
//   iq_tvalid/iq_tready       : AXI-S handshake
//   iq_tlast                  : last beat of a frame
//   iq_first                  : one-cycle frame-start strobe
//   counter_id                : frame number, constant across the frame
interface iq_frame_builder_if;
   logic [31:0] adc_iq_tdata;
   logic [31:0] dac_iq_tdata;
   logic        iq_tvalid;
   logic        iq_tlast;
   logic        iq_tready;
   logic        iq_first;
   logic [63:0] counter_id;

   modport master (
      output adc_iq_tdata, dac_iq_tdata, iq_tvalid, iq_tlast, iq_first, counter_id,
      input  iq_tready
   );

   modport slave (
      input  adc_iq_tdata, dac_iq_tdata, iq_tvalid, iq_tlast, iq_first, counter_id,
      output iq_tready
   );
endinterface

// File: rtl/iq_frame_builder.sv
// Cuts one FFT_LEN-beat frame per chirp out of the free-running ADC/DAC
// sample stream, delaying the DAC reference by dac_delay samples.
//   aclk, aresetn (sync, active-low)
//   adc_tdata/dac_tdata/sample_valid : paired input samples, no backpressure
//   chirp_active, frame_enable       : frame start control
//   dac_delay                        : DAC delay in samples, latched per frame
//   ovf_clear                        : clears overflow and drop_count
//   iq                               : framed output stream (master)
//   overflow, drop_count, busy       : status
module iq_frame_builder #(
   parameter int unsigned FFT_LEN     = 4096,
   parameter int unsigned DELAY_DEPTH = 64
) (
   input  logic                           aclk,
   input  logic                           aresetn,
   input  logic [31:0]                    adc_tdata,
   input  logic [31:0]                    dac_tdata,
   input  logic                           sample_valid,
   input  logic                           chirp_active,
   input  logic                           frame_enable,
   input  logic [$clog2(DELAY_DEPTH)-1:0] dac_delay,
   input  logic                           ovf_clear,
   iq_frame_builder_if.master             iq,
   output logic                           overflow,
   output logic [15:0]                    drop_count,
   output logic                           busy
);

   localparam int unsigned BEAT_W = $clog2(FFT_LEN);
   localparam int unsigned PTR_W  = $clog2(DELAY_DEPTH);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(FFT_LEN - 1);
   localparam logic [PTR_W:0]    FILL_MAX  = (PTR_W + 1)'(DELAY_DEPTH);

   typedef enum logic [2:0] {S_IDLE, S_CAPTURE, S_PAD, S_DRAIN, S_HOLDOFF} state_e;

   state_e             state_q, state_d;
   logic               chirp_q;
   logic [31:0]        mem_q [DELAY_DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q;
   logic [PTR_W:0]     fill_q;
   logic [PTR_W-1:0]   delay_q, delay_d;
   logic [BEAT_W-1:0]  beat_q, beat_d;
   logic [31:0]        adc_q, adc_d, dac_q, dac_d;
   logic               tvalid_q, tvalid_d, tlast_q, tlast_d, first_q, first_d;
   logic [63:0]        cid_q, cid_d;
   logic               ovf_q, ovf_d, busy_q;
   logic [15:0]        drop_q, drop_d;

   logic               rise_c, free_c, hs_c, capture_c, pad_c;
   logic [PTR_W-1:0]   delay_eff_c, rd_idx_c;
   logic [BEAT_W-1:0]  beat_cur_c;
   logic [31:0]        dac_dly_c;

   // Delay-line storage; contents are qualified by fill_q so no reset is needed.
   always_ff @(posedge aclk) begin
      if (sample_valid) begin
         mem_q[wr_ptr_q] <= dac_tdata;
      end
   end

   // Write pointer and fill level advance on every sample, in every state.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         wr_ptr_q <= '0;
         fill_q   <= '0;
      end else if (sample_valid) begin
         wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (fill_q != FILL_MAX) begin
            fill_q <= fill_q + (PTR_W + 1)'(1);
         end
      end
   end

   // Delayed DAC read; in IDLE the live dac_delay applies so the rise-cycle
   // sample uses the value being latched.
   always_comb begin
      delay_eff_c = (state_q == S_IDLE) ? dac_delay : delay_q;
      rd_idx_c    = wr_ptr_q - delay_eff_c;
      if (delay_eff_c == '0) begin
         dac_dly_c = dac_tdata;
      end else if (fill_q < (PTR_W + 1)'(delay_eff_c)) begin
         dac_dly_c = 32'h0;
      end else begin
         dac_dly_c = mem_q[rd_idx_c];
      end
   end

   // Next-state and output-register logic.
   always_comb begin
      state_d   = state_q;
      delay_d   = delay_q;
      beat_d    = beat_q;
      adc_d     = adc_q;
      dac_d     = dac_q;
      tvalid_d  = tvalid_q;
      tlast_d   = tlast_q;
      first_d   = 1'b0;
      cid_d     = cid_q;
      ovf_d     = ovf_q;
      drop_d    = drop_q;
      capture_c = 1'b0;
      pad_c     = 1'b0;
      rise_c    = chirp_active & ~chirp_q;
      free_c    = ~tvalid_q | iq.iq_tready;
      hs_c      = tvalid_q & iq.iq_tready;
      beat_cur_c = (state_q == S_IDLE) ? '0 : beat_q;

      if (hs_c) begin
         tvalid_d = 1'b0;
         tlast_d  = 1'b0;
      end
      if (ovf_clear) begin
         ovf_d  = 1'b0;
         drop_d = 16'h0;
      end

      case (state_q)
         S_IDLE: begin
            if (rise_c && frame_enable) begin
               cid_d     = cid_q + 64'd1;
               delay_d   = dac_delay;
               beat_d    = '0;
               state_d   = S_CAPTURE;
               capture_c = sample_valid;
            end
         end
         S_CAPTURE: begin
            if (sample_valid) begin
               if (free_c) begin
                  capture_c = 1'b1;
               end else begin
                  // Dropped sample: the beat count holds so the frame stays FFT_LEN long.
                  ovf_d  = 1'b1;
                  drop_d = (drop_q == 16'hFFFF) ? drop_q : drop_q + 16'd1;
               end
            end else if (!chirp_active) begin
               state_d = S_PAD;
            end
         end
         S_PAD: pad_c = free_c;
         S_DRAIN: begin
            if (hs_c && tlast_q) begin
               state_d = chirp_active ? S_HOLDOFF : S_IDLE;
            end
         end
         S_HOLDOFF: begin
            if (!chirp_active) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (capture_c || pad_c) begin
         adc_d    = capture_c ? adc_tdata : 32'h0;
         dac_d    = capture_c ? dac_dly_c : 32'h0;
         tvalid_d = 1'b1;
         tlast_d  = (beat_cur_c == LAST_BEAT);
         first_d  = (beat_cur_c == '0);
         beat_d   = beat_cur_c + BEAT_W'(1);
         if (beat_cur_c == LAST_BEAT) begin
            state_d = S_DRAIN;
         end
      end
   end

   // State and output registers.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state_q  <= S_IDLE;
         chirp_q  <= 1'b0;
         delay_q  <= '0;
         beat_q   <= '0;
         adc_q    <= 32'h0;
         dac_q    <= 32'h0;
         tvalid_q <= 1'b0;
         tlast_q  <= 1'b0;
         first_q  <= 1'b0;
         cid_q    <= 64'h0;
         ovf_q    <= 1'b0;
         drop_q   <= 16'h0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         chirp_q  <= chirp_active;
         delay_q  <= delay_d;
         beat_q   <= beat_d;
         adc_q    <= adc_d;
         dac_q    <= dac_d;
         tvalid_q <= tvalid_d;
         tlast_q  <= tlast_d;
         first_q  <= first_d;
         cid_q    <= cid_d;
         ovf_q    <= ovf_d;
         drop_q   <= drop_d;
         busy_q   <= (state_d != S_IDLE);
      end
   end

   assign iq.adc_iq_tdata = adc_q;
   assign iq.dac_iq_tdata = dac_q;
   assign iq.iq_tvalid    = tvalid_q;
   assign iq.iq_tlast     = tlast_q;
   assign iq.iq_first     = first_q;
   assign iq.counter_id   = cid_q;
   assign overflow        = ovf_q;
   assign drop_count      = drop_q;
   assign busy            = busy_q;

endmodule

// File: tb/tb_iq_frame_builder.sv
// Bench for iq_frame_builder: frame scenarios from a table plus hand-written
// overflow and mid-frame reset sequences; expected beats go through a queue.
module tb_iq_frame_builder;
   localparam int unsigned LEN = 16;
   localparam int unsigned DD  = 8;
   localparam int NV = 7;

   typedef struct {
      logic [31:0] adc;
      logic [31:0] dac;
      logic        last;
      logic [63:0] cid;
   } beat_t;

   typedef struct {
      int n_high;
      int delay;
      bit en;
      int pre;
      bit rdy_rand;
      int exp_beats;
      int exp_inc;
   } vec_t;

   logic        aclk = 1'b0;
   logic        aresetn;
   logic [31:0] adc_tdata, dac_tdata;
   logic        sample_valid, chirp_active, frame_enable, ovf_clear;
   logic [2:0]  dac_delay;
   logic        overflow, busy;
   logic [15:0] drop_count;

   iq_frame_builder_if s_if ();

   iq_frame_builder #(.FFT_LEN(LEN), .DELAY_DEPTH(DD)) dut (
      .aclk         (aclk),
      .aresetn      (aresetn),
      .adc_tdata    (adc_tdata),
      .dac_tdata    (dac_tdata),
      .sample_valid (sample_valid),
      .chirp_active (chirp_active),
      .frame_enable (frame_enable),
      .dac_delay    (dac_delay),
      .ovf_clear    (ovf_clear),
      .iq           (s_if),
      .overflow     (overflow),
      .drop_count   (drop_count),
      .busy         (busy)
   );

   always #5 aclk = ~aclk;

   beat_t       sb[$];
   vec_t        vecs[NV];
   int          checks, errors;
   int          g;
   logic [63:0] cid_exp;
   int          hs_total, hs_cnt;
   bit          stalled;

   function automatic logic [31:0] adc_of(int k);
      return 32'hA000_0000 | 32'(k);
   endfunction

   function automatic logic [31:0] dac_of(int k);
      return 32'hD000_0000 | 32'(k);
   endfunction

   // Reference: DAC sample k delayed by d is sample k-d, or zero before it exists.
   function automatic logic [31:0] dly_exp(int k, int d);
      return (k >= d) ? dac_of(k - d) : 32'h0;
   endfunction

   task automatic check(string name, logic [255:0] act, logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_int(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_zero(string name);
      check(name, 256'({s_if.adc_iq_tdata, s_if.dac_iq_tdata, s_if.iq_tvalid, s_if.iq_tlast,
                        s_if.iq_first, s_if.counter_id, overflow, drop_count, busy}), 256'(0));
   endtask

   task automatic step();
      @(posedge aclk);
      #1;
   endtask

   task automatic send(bit c, bit sv);
      chirp_active = c;
      sample_valid = sv;
      adc_tdata    = sv ? adc_of(g) : $urandom;
      dac_tdata    = sv ? dac_of(g) : $urandom;
      step();
      if (sv) g++;
   endtask

   task automatic push(logic [31:0] a, logic [31:0] d, int idx);
      beat_t b;
      b.adc  = a;
      b.dac  = d;
      b.last = (idx == LEN - 1);
      b.cid  = cid_exp;
      sb.push_back(b);
   endtask

   // Handshake monitor: pops the scoreboard and checks the iq_first strobe.
   task automatic monitor();
      beat_t b;
      logic  ef;
      forever begin
         @(negedge aclk);
         if (!aresetn) begin
            hs_cnt  = 0;
            stalled = 1'b0;
         end else begin
            ef = s_if.iq_tvalid && (hs_cnt == 0) && !stalled;
            if (s_if.iq_first || ef) check("iq_first", 256'(s_if.iq_first), 256'(ef));
            if (s_if.iq_tvalid && s_if.iq_tready) begin
               if (sb.size() == 0) begin
                  check_int("unexpected_beat", 1, 0);
               end else begin
                  b = sb.pop_front();
                  check($sformatf("beat%0d", hs_cnt),
                        256'({s_if.adc_iq_tdata, s_if.dac_iq_tdata, s_if.iq_tlast, s_if.counter_id}),
                        256'({b.adc, b.dac, b.last, b.cid}));
               end
               hs_total++;
               hs_cnt = s_if.iq_tlast ? 0 : hs_cnt + 1;
            end
            stalled = s_if.iq_tvalid && !s_if.iq_tready;
         end
      end
   endtask

   task automatic finish_frame(bit rr, int exp_beats, int hs0);
      int t = 0;
      while ((sb.size() != 0 || busy) && t < 300) begin
         s_if.iq_tready = rr ? 1'($urandom_range(0, 1)) : 1'b1;
         send(1'b0, 1'b0);
         t++;
      end
      s_if.iq_tready = 1'b1;
      check_int("frame_timeout", int'(t < 300), 1);
      if (t >= 300) sb.delete();
      send(1'b0, 1'b0);
      check_int("beat_count", hs_total - hs0, exp_beats);
      check("counter_id", 256'(s_if.counter_id), 256'(cid_exp));
      check("busy_idle", 256'(busy), 256'(0));
   endtask

   task automatic run_frame(vec_t v);
      int hs0 = hs_total;
      frame_enable   = v.en;
      dac_delay      = 3'(v.delay);
      s_if.iq_tready = 1'b1;
      repeat (v.pre) send(1'b0, 1'b1);
      cid_exp = cid_exp + 64'(v.exp_inc);
      for (int i = 0; i < v.n_high; i++) begin
         if (v.en && i < LEN) push(adc_of(g), dly_exp(g, v.delay), i);
         send(1'b1, 1'b1);
         if (i == 0) begin
            // Mid-frame changes to delay and enable must be ignored.
            dac_delay    = 3'($urandom_range(0, DD - 1));
            frame_enable = 1'($urandom_range(0, 1));
         end
      end
      if (v.en) for (int i = v.n_high; i < LEN; i++) push(32'h0, 32'h0, i);
      finish_frame(v.rdy_rand, v.exp_beats, hs0);
   endtask

   initial begin
      int hs0;
      vecs[0] = '{20, 3, 1'b1, 0, 1'b0, LEN, 1};   // full frame, delay from reset
      vecs[1] = '{10, 0, 1'b1, 3, 1'b0, LEN, 1};   // short chirp, zero padding
      vecs[2] = '{16, 5, 1'b1, 4, 1'b0, LEN, 1};   // exact length
      vecs[3] = '{ 5, 2, 1'b1, 2, 1'b1, LEN, 1};   // padding under backpressure
      vecs[4] = '{12, 0, 1'b0, 2, 1'b0, 0,   0};   // frame_enable low at rise
      vecs[5] = '{16, 7, 1'b1, 1, 1'b0, LEN, 1};   // maximum delay
      vecs[6] = '{ 1, 1, 1'b1, 9, 1'b0, LEN, 1};   // single sample, full delay line

      checks = 0; errors = 0; g = 0; cid_exp = 64'h0;
      hs_total = 0; hs_cnt = 0; stalled = 1'b0;
      aresetn = 1'b0; chirp_active = 1'b0; sample_valid = 1'b0; frame_enable = 1'b0;
      dac_delay = 3'd0; ovf_clear = 1'b0; adc_tdata = 32'h0; dac_tdata = 32'h0;
      s_if.iq_tready = 1'b1;
      fork monitor(); join_none

      step(); step(); step();
      check_zero("reset_state");
      aresetn = 1'b1;

      for (int i = 0; i < NV; i++) run_frame(vecs[i]);

      // Overflow: output stalled for the rise cycle and the two after it.
      hs0 = hs_total;
      frame_enable = 1'b1;
      dac_delay = 3'd0;
      check("ovf_before", 256'({overflow, drop_count}), 256'(0));
      cid_exp = cid_exp + 64'd1;
      for (int i = 0; i < 18; i++) begin
         s_if.iq_tready = (i >= 3);
         if (i == 0) push(adc_of(g), dac_of(g), 0);
         else if (i >= 3) push(adc_of(g), dac_of(g), i - 2);
         send(1'b1, 1'b1);
      end
      finish_frame(1'b0, LEN, hs0);
      check("ovf_set", 256'({overflow, drop_count}), 256'({1'b1, 16'd2}));
      ovf_clear = 1'b1;
      send(1'b0, 1'b1);
      ovf_clear = 1'b0;
      check("ovf_clear", 256'({overflow, drop_count}), 256'(0));

      // Reset while beat 7 is waiting in the output register.
      frame_enable = 1'b1;
      s_if.iq_tready = 1'b1;
      send(1'b0, 1'b1);
      cid_exp = cid_exp + 64'd1;
      for (int i = 0; i < 8; i++) begin
         if (i < 7) push(adc_of(g), dac_of(g), i);
         send(1'b1, 1'b1);
      end
      aresetn = 1'b0;
      s_if.iq_tready = 1'b0;
      send(1'b1, 1'b0);
      check_zero("reset_mid_frame");
      check_int("beats_before_reset", sb.size(), 0);
      sb.delete();
      aresetn = 1'b1;
      s_if.iq_tready = 1'b1;
      g = 0;
      cid_exp = 64'h0;
      send(1'b0, 1'b0);
      run_frame('{16, 0, 1'b1, 2, 1'b0, LEN, 1});

      check_int("scoreboard_empty", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/iq_frame_builder.md
# iq_frame_builder

Upstream framing stage for the matched-filter range detector. It takes the free-running paired ADC/DAC IQ sample stream, delays the DAC reference by a programmable number of samples, and cuts one FFT_LEN-sample frame per chirp. Each frame carries `iq_first`, `iq_tlast` and a 64-bit `counter_id`. Short chirps are zero-padded to FFT_LEN; long chirps are truncated. The output drives the detector's `adc_iq_tdata`/`dac_iq_tdata`/`iq_*`/`counter_id` inputs directly.

## Interface
- FFT_LEN, 4096: samples per frame; power of two, 16..65536.
- DELAY_DEPTH, 64: DAC delay-line entries; power of two.
- aclk  in  1  clock.
- aresetn  in  1  reset, synchronous, active-low.
- adc_tdata  in  32  ADC sample {I[31:16],Q[15:0]}.
- dac_tdata  in  32  DAC sample, same packing.
- sample_valid  in  1  ADC/DAC pair valid this cycle. There is no backpressure on the input.
- chirp_active  in  1  chirp window from the control module.
- frame_enable  in  1  allows frame start (adc_enable).
- dac_delay  in  log2(DELAY_DEPTH)  DAC delay in samples.
- ovf_clear  in  1  clears `overflow`.
- adc_iq_tdata  out  32  framed ADC sample.
- dac_iq_tdata  out  32  framed, delayed DAC sample.
- iq_tvalid  out  1  AXI-S valid.
- iq_tlast  out  1  last beat of frame (beat FFT_LEN-1).
- iq_tready  in  1  AXI-S ready.
- iq_first  out  1  one-cycle frame-start strobe.
- counter_id  out  64  frame number, held constant for the whole frame.
- overflow  out  1  sticky sample-drop flag.
- drop_count  out  16  dropped samples, saturating.
- busy  out  1  high when the state is not IDLE.

## Operation
**Reset values.** All outputs reset to 0, state resets to IDLE, and the delay-line fill counter resets to 0.

**DAC delay line.**
- Circular buffer of DELAY_DEPTH entries. The write pointer advances on every `sample_valid`, in every state.
- Read index = wr_ptr − `dac_delay`. Delay 0 passes the current input through.
- The read returns 0 while fill < delay. Fill saturates at DELAY_DEPTH.
- `dac_delay` is latched at frame start; changes during a frame are ignored.

**Start condition.** rise = `chirp_active` & !`chirp_active` delayed by 1 cycle.

**FSM: IDLE → CAPTURE.**
- Trigger: rise & `frame_enable`.
- Actions: `counter_id` += 1, latch `dac_delay`, beat count = 0.
- The first captured pair is the `sample_valid` pair in the rise cycle or any later cycle.

**FSM: CAPTURE.**
- Each `sample_valid` loads the output register and increments the beat count.
- Loading beat FFT_LEN−1 sets `iq_tlast`. → DRAIN.
- If `chirp_active` is low and there is no `sample_valid` in a cycle: → PAD.

**FSM: PAD.**
- Loads zero beats (both ADC and DAC = 0) on every cycle the output register is free, i.e. (!`iq_tvalid` | `iq_tready`).
- Beat FFT_LEN−1 carries `iq_tlast`. → DRAIN.

**FSM: DRAIN.**
- On the `iq_tlast` handshake: → HOLDOFF if `chirp_active` is high, else → IDLE.

**FSM: HOLDOFF.**
- Waits for `chirp_active` low, then → IDLE. No frame starts while in HOLDOFF.

**Overflow.**
- Condition: in CAPTURE, `sample_valid` while `iq_tvalid` & !`iq_tready`.
- The sample is dropped and the beat count does not advance.
- `overflow` is set to 1 and `drop_count` += 1, saturating at 0xFFFF.
- The frame still completes with exactly FFT_LEN beats.
- `ovf_clear` clears both `overflow` and `drop_count`. A set event in the same cycle wins.

**Enable and flag rules.**
- Deasserting `frame_enable` mid-frame has no effect; the frame completes.
- `iq_first` is high for exactly one cycle: the first cycle in which beat 0 is valid. It is not gated by `iq_tready`.

**Width and wrap.** Beat counter width is log2(FFT_LEN). `counter_id` wraps from 2^64−1 to 0.

## Timing
- Latency: `sample_valid` in cycle N → `iq_tvalid` in cycle N+1, at any `dac_delay`.
- Single output register. Data, `iq_tlast` and `counter_id` are held stable while `iq_tvalid` & !`iq_tready`.
- Throughput: one beat per cycle in CAPTURE and in PAD.
- A PAD frame at full `iq_tready` completes in FFT_LEN − n cycles after the fall of `chirp_active`, where n is the number of samples captured.
- Rise on the same cycle as the DRAIN → IDLE transition: ignored, because the frame start requires IDLE at the rise.
- Reset mid-frame: the next cycle has all outputs at 0 and the partial frame is discarded.
- The downstream FFT shares `aresetn`.

## Test plan
1. **Full frame.** FFT_LEN=16, delay 0, `iq_tready`=1, ramp adc=k, dac=k, chirp high for 20 samples → 16 beats adc=0..15, `iq_tlast` on beat 15, a single `iq_first`, `counter_id`=1. No second frame until `chirp_active` falls and rises again.
2. **Short chirp.** Chirp high for 10 samples → beats 0..9 are data, beats 10..15 are zero on consecutive cycles, `iq_tlast` on beat 15, `busy` falls after the handshake.
3. **DAC delay.** `dac_delay`=3, ramp started right after reset, chirp at sample 0 → dac beats 0,0,0,0,1,2…; adc beats 0,1,2…
4. **Overflow.** `iq_tready` low for 3 cycles during CAPTURE with `sample_valid` every cycle → `overflow`=1, `drop_count`=2, 16 beats total. Then `ovf_clear` → both return to 0.
5. **Enable gating.** `frame_enable`=0 at the rise → no beats, `counter_id` unchanged. Next rise with `frame_enable`=1 → `counter_id`=+1.
6. **Reset mid-frame.** `aresetn` low at beat 7 → all outputs 0 the next cycle. The next chirp yields `counter_id`=1 and a clean 16-beat frame.
